seq_shift_controller: RTL

- Multi-cycle shifter that performs a variable-amount shift with a valid/ready handshake.
- Each cycle it drives one fixed-stride shift stage, either by STEP bits or by 1 bit, and counts down the remaining amount.
- It sits between a producer and a consumer as a small-area alternative to a full barrel shifter.
- It covers logical left, logical right and arithmetic right shifts.

---
 rtl/seq_shift_pkg.sv | 15 +
 rtl/shift_step_stage.sv | 48 ++++
 rtl/seq_shift_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seq_shift_pkg.sv
// Shared types and constants for the multi-cycle shift controller.
package seq_shift_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Shift direction encoding on up_dir
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step_stage.sv
// One fixed-stride shift stage: shifts by STEP (coarse) or by 1 bit.
// Right shifts fill with zeros, or with the current MSB when arith is set.
module shift_step_stage
    import seq_shift_pkg::*;
#(
    parameter int N    = 8,
    parameter int STEP = 3
) (
    input  logic [N-1:0] data,
    input  logic         dir,
    input  logic         arith,
    input  logic         coarse,
    output logic [N-1:0] shifted
);

    logic [N-1:0] shl_s;
    logic [N-1:0] shr_s;
    logic [N-1:0] sra_s;

    // Candidate results for the selected stride
    always_comb begin
        shl_s = '0;
        shr_s = '0;
        sra_s = '0;
        if (coarse) begin
            shl_s = data << STEP;
            shr_s = data >> STEP;
            sra_s = $signed(data) >>> STEP;
        end else begin
            shl_s = data << 1'b1;
            shr_s = data >> 1'b1;
            sra_s = $signed(data) >>> 1'b1;
        end
    end

    // Pick the result for the requested direction and fill mode
    always_comb begin
        shifted = '0;
        if (dir == DIR_LEFT) begin
            shifted = shl_s;
        end else if (arith) begin
            shifted = sra_s;
        end else begin
            shifted = shr_s;
        end
    end

endmodule

// File: rtl/seq_shift_controller.sv
// Multi-cycle variable-amount shifter with valid/ready on both sides.
// The working register doubles as the result register (down_data).
// Amounts are clamped to N; each SHIFT cycle moves STEP bits while at least
// STEP remain, otherwise 1 bit.
module seq_shift_controller
    import seq_shift_pkg::*;
#(
    parameter int N    = 8,
    parameter int STEP = 3,
    parameter int AW   = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [AW-1:0] up_amount,
    input  logic          up_dir,
    input  logic          up_arith,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data,
    output logic          busy
);

    localparam logic [AW-1:0] AMT_MAX  = AW'(N);
    localparam logic [AW-1:0] AMT_STEP = AW'(STEP);
    localparam logic [AW-1:0] AMT_ONE  = AW'(1);

    state_e        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic          dir_q, dir_d;
    logic          arith_q, arith_d;
    logic [AW-1:0] rem_q, rem_d;
    logic          down_valid_q, down_valid_d;
    logic          busy_q, busy_d;

    logic [AW-1:0] amt_clamped_s;
    logic          coarse_s;
    logic [N-1:0]  stage_out_s;

    shift_step_stage #(
        .N    (N),
        .STEP (STEP)
    ) u_stage (
        .data    (data_q),
        .dir     (dir_q),
        .arith   (arith_q),
        .coarse  (coarse_s),
        .shifted (stage_out_s)
    );

    // Clamp the requested amount and choose the stride for this iteration
    always_comb begin
        amt_clamped_s = up_amount;
        if (up_amount > AMT_MAX) begin
            amt_clamped_s = AMT_MAX;
        end else begin
            amt_clamped_s = up_amount;
        end
        coarse_s = (rem_q >= AMT_STEP);
    end

    // Next-state logic for the FSM, working register and remaining count
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (up_valid) begin
                    data_d  = up_data;
                    dir_d   = up_dir;
                    arith_d = up_arith;
                    rem_d   = amt_clamped_s;
                    if (amt_clamped_s == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d = stage_out_s;
                if (coarse_s) begin
                    rem_d = rem_q - AMT_STEP;
                end else begin
                    rem_d = rem_q - AMT_ONE;
                end
                if (rem_d == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (down_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output flags follow the next state so they are flop outputs
    always_comb begin
        down_valid_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            dir_q        <= DIR_LEFT;
            arith_q      <= 1'b0;
            rem_q        <= '0;
            down_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            dir_q        <= dir_d;
            arith_q      <= arith_d;
            rem_q        <= rem_d;
            down_valid_q <= down_valid_d;
            busy_q       <= busy_d;
        end
    end

    // up_ready is a pure decode of the registered state
    always_comb begin
        up_ready   = (state_q == IDLE);
        down_valid = down_valid_q;
        down_data  = data_q;
        busy       = busy_q;
    end

endmodule
